// File: rtl/defuse_pkg.sv
// Shared types and timing constants for the key conditioning path.
package defuse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned CLK_HZ           = 50_000_000;
  // 20 ms of stable input before a transition is accepted.
  localparam int unsigned DEBOUNCE_DEFAULT = CLK_HZ / 50;
  // 2 s of accepted press before a long-press event.
  localparam int unsigned HOLD_DEFAULT     = CLK_HZ * 2;

endpackage

// File: rtl/key_debounce_fsm.sv
// Single-key synchroniser, debounce FSM and press/release/hold pulse generator.
// Long-press detection is built only when KEY_HOLD_DETECT_EN is defined.
module key_debounce_fsm
  import defuse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;

  // Both flops reset high so an idle key reads as released.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let sync2 take sync1's old value, forming a true two-stage chain.
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_press_nxt = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
          w_level_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef KEY_HOLD_DETECT_EN
  localparam int unsigned     HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              r_hold;
  logic              w_hold_nxt;

  // The counter saturates, so a bounce back into HELD never re-fires the pulse.
  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    w_hold_nxt     = 1'b0;
    if (r_state == PRESS_WAIT && w_state_nxt == HELD) begin
      w_hold_cnt_nxt = '0;
    end else if (r_state == HELD && w_pressed && r_hold_cnt != HOLD_LAST) begin
      w_hold_cnt_nxt = r_hold_cnt + 1'b1;
      w_hold_nxt     = (w_hold_cnt_nxt == HOLD_LAST);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  assign o_hold = r_hold;
`else
  assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Synchronises and debounces NUM_KEYS active-low board keys into clean level/pulse outputs.
// Define KEY_HOLD_DETECT_EN to enable the long-press key_hold pulse.
module key_conditioner
  import defuse_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_key (
      .clock    (clock),
      .resetn   (resetn),
      .i_key_n  (key_n[i]),
      .o_level  (key_level[i]),
      .o_press  (key_press[i]),
      .o_release(key_release[i]),
      .o_hold   (key_hold[i])
    );
  end

endmodule
